// File: rtl/k005297_relpg_reader.sv
// Receiver for the 005297 bit-serial relative page stream: deserializes the 12-bit
// page word framed by the 20-phase timing ring and checks it against the counter sequence.
module k005297_relpg_reader (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CLK2M_PCEN_n,
    input  logic [19:0] i_ROT20_n,
    input  logic        i_RELPG_SDATA,
    input  logic        i_CNT_EN,
    input  logic        i_TRACK_EN,
    input  logic        i_ERR_CLR,
    input  logic [11:0] i_TARGET_PG,
    output logic [11:0] o_PAGE,
    output logic        o_PG_STB,
    output logic        o_MATCH,
    output logic        o_SEQ_ERR,
    output logic        o_RANGE_ERR,
    output logic        o_TRACKING
);
    localparam logic [11:0] PG_MOD  = 12'd2053;
    localparam logic [11:0] PG_UP   = 12'd522;
    localparam logic [11:0] PG_DOWN = 12'd1531;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] sreg_q, sreg_d;
    logic [11:0] prev_q, prev_d;
    logic [11:0] page_q, page_d;
    logic        fv_q, fv_d;
    logic        cnt_en_f_q, cnt_en_f_d;
    logic        stb_q, stb_d;
    logic        match_q, match_d;
    logic        seq_err_q, seq_err_d;
    logic        range_err_q, range_err_d;

    logic        tick, ring_ok, vtick, done, range_bad;
    logic        prev_load, seq_set, tracking;
    logic [4:0]  phase, zero_cnt;
    logic [11:0] nxt_pg;

    // Ring is well formed only when exactly one phase line is low.
    always_comb begin
        phase    = '0;
        zero_cnt = '0;
        for (int i = 0; i < 20; i++) begin
            if (!i_ROT20_n[i]) begin
                zero_cnt = zero_cnt + 5'd1;
                phase    = 5'(i);
            end
        end
    end

    assign tick      = ~i_CLK2M_PCEN_n;
    assign ring_ok   = (zero_cnt == 5'd1);
    assign vtick     = tick & ring_ok;
    assign done      = vtick & (phase == 5'd12) & fv_q;
    assign range_bad = (sreg_q >= PG_MOD);
    assign nxt_pg    = !cnt_en_f_q          ? prev_q :
                       (prev_q >= PG_DOWN)  ? prev_q - PG_DOWN : prev_q + PG_UP;

    always_comb begin
        sreg_d      = sreg_q;
        fv_d        = fv_q;
        cnt_en_f_d  = cnt_en_f_q;
        page_d      = page_q;
        match_d     = match_q;
        stb_d       = done;
        prev_d      = prev_load ? sreg_q : prev_q;
        seq_err_d   = seq_err_q;
        range_err_d = range_err_q;
        if (tick && !ring_ok) begin
            fv_d = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            if (vtick && phase == 5'(k)) begin
                sreg_d[k] = i_RELPG_SDATA;
            end
        end
        if (vtick && phase == 5'd0) begin
            fv_d       = 1'b1;
            cnt_en_f_d = i_CNT_EN;
        end
        if (done) begin
            page_d  = sreg_q;
            match_d = (sreg_q == i_TARGET_PG);
        end
        // Clear first so a flag raised on the same tick survives.
        if (vtick && i_ERR_CLR) begin
            seq_err_d   = 1'b0;
            range_err_d = 1'b0;
        end
        if (seq_set) begin
            seq_err_d = 1'b1;
        end
        if (done && range_bad) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vtick) begin
            if (!i_TRACK_EN) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:  state_d = ST_SYNC;
                    ST_SYNC:  if (done && !range_bad) state_d = ST_TRACK;
                    ST_TRACK: if (done && range_bad)  state_d = ST_SYNC;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Sequence check is skipped when tracking is dropped on the completion tick.
    always_comb begin
        prev_load = 1'b0;
        seq_set   = 1'b0;
        tracking  = (state_q == ST_TRACK);
        if (done && i_TRACK_EN) begin
            case (state_q)
                ST_SYNC: begin
                    prev_load = !range_bad;
                end
                ST_TRACK: begin
                    prev_load = 1'b1;
                    seq_set   = range_bad || (sreg_q != nxt_pg);
                end
                default: begin
                    prev_load = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sreg_q      <= '0;
            prev_q      <= '0;
            page_q      <= '0;
            fv_q        <= 1'b0;
            cnt_en_f_q  <= 1'b0;
            stb_q       <= 1'b0;
            match_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            prev_q      <= prev_d;
            page_q      <= page_d;
            fv_q        <= fv_d;
            cnt_en_f_q  <= cnt_en_f_d;
            stb_q       <= stb_d;
            match_q     <= match_d;
            seq_err_q   <= seq_err_d;
            range_err_q <= range_err_d;
        end
    end

    assign o_PAGE      = page_q;
    assign o_PG_STB    = stb_q;
    assign o_MATCH     = match_q;
    assign o_SEQ_ERR   = seq_err_q;
    assign o_RANGE_ERR = range_err_q;
    assign o_TRACKING  = tracking;

endmodule
